// File: rtl/pcre_l.sv
// One 16-bit stage of the daisy-chained match-vector serializer: captures a slice of
// the hit vector on eop and emits one rule ID per set bit while it holds the chain token.
module pcre_l #(
    parameter int VEC_MSB = 15,
    parameter int IDX_W   = 4,
    parameter int BASE    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             perm_in,
    input  logic [VEC_MSB:0] vector,
    input  logic             eop,
    output logic             perm_out,
    output logic [9:0]       rule
);

    localparam logic [VEC_MSB:0] ONE_LSB = (VEC_MSB + 1)'(1);
    localparam logic [9:0]       ID_OFS  = 10'(BASE + 1);

    logic [VEC_MSB:0] pending_q, pending_d;
    logic [9:0]       rule_q, rule_d;
    logic             perm_out_q, perm_out_d;
    logic [IDX_W-1:0] low_idx;
    logic             has_pending;

    assign has_pending = |pending_q;

    // Descending scan so the last hit written is the lowest set index.
    always_comb begin
        low_idx = '0;
        for (int i = VEC_MSB; i >= 0; i--) begin
            if (pending_q[i]) low_idx = IDX_W'(i);
        end
    end

    always_comb begin
        pending_d  = pending_q;
        rule_d     = '0;
        perm_out_d = 1'b0;
        if (eop) begin
            pending_d = vector;
        end else if (perm_in && has_pending) begin
            rule_d    = ID_OFS + 10'(low_idx);
            pending_d = pending_q & (pending_q - ONE_LSB);
        end else begin
            perm_out_d = perm_in & ~has_pending;
        end
    end

    // NOTE: reset is sampled on the clock edge only, so it appears inside the clocked
    // branch and not in the sensitivity list; it still overrides eop and an active scan.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_q  <= '0;
            rule_q     <= '0;
            perm_out_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            rule_q     <= rule_d;
            perm_out_q <= perm_out_d;
        end
    end

    assign rule     = rule_q;
    assign perm_out = perm_out_q;

endmodule

// File: tb/tb_pcre_l.sv
// Bench for pcre_l: two stages (BASE=0 and BASE=16) share stimulus; directed scenarios
// use hand-derived expectations, random traffic is checked against a queue-based model.
module tb_pcre_l;

    logic        clk = 1'b0;
    logic        rst;
    logic        perm_in;
    logic        eop;
    logic [15:0] vector;
    logic        po0, po16;
    logic [9:0]  r0, r16;

    int total = 0;
    int bad   = 0;

    // Model: queue of bit indices still to be emitted, lowest first.
    int   mq[$];
    int   exp_idx;
    logic exp_po;

    always #5 clk = ~clk;

    pcre_l #(.VEC_MSB(15), .IDX_W(4), .BASE(0)) dut_b0 (
        .clk(clk), .rst(rst), .perm_in(perm_in), .vector(vector), .eop(eop),
        .perm_out(po0), .rule(r0)
    );

    pcre_l #(.VEC_MSB(15), .IDX_W(4), .BASE(16)) dut_b16 (
        .clk(clk), .rst(rst), .perm_in(perm_in), .vector(vector), .eop(eop),
        .perm_out(po16), .rule(r16)
    );

    function automatic logic [9:0] exp_rule(input int base);
        return (exp_idx < 0) ? 10'd0 : 10'((base + exp_idx + 1) % 1024);
    endfunction

    // Apply one cycle of inputs, advance the model at the edge, settle 1 time unit after.
    task automatic cycle(input logic r, input logic pi, input logic e, input logic [15:0] v);
        rst = r; perm_in = pi; eop = e; vector = v;
        @(posedge clk);
        if (!r) begin
            mq.delete(); exp_idx = -1; exp_po = 1'b0;
        end else if (e) begin
            mq.delete();
            for (int i = 0; i < 16; i++) if (v[i]) mq.push_back(i);
            exp_idx = -1; exp_po = 1'b0;
        end else if (pi && mq.size() > 0) begin
            exp_idx = mq.pop_front(); exp_po = 1'b0;
        end else begin
            exp_idx = -1; exp_po = pi && (mq.size() == 0);
        end
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            cycle(1'b0, 1'b1, 1'b1, 16'hFFFF);
            total++;
            if ({po0, r0, po16, r16} !== {1'b0, 10'd0, 1'b0, 10'd0}) begin
                bad++;
                $display("FAIL reset c%0d: got po0=%b r0=%0d po16=%b r16=%0d, want all 0",
                         k, po0, r0, po16, r16);
            end
        end
    endtask

    task automatic test_basic_drain();
        int w_r16[4] = '{0, 17, 19, 0};
        logic w_po[4] = '{0, 0, 0, 1};
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b1, k == 0, 16'h0005);
            total++;
            if ({po16, r16, po0, r0} !== {w_po[k], 10'(w_r16[k]), w_po[k],
                                          10'(w_r16[k] == 0 ? 0 : w_r16[k] - 16)}) begin
                bad++;
                $display("FAIL basic_drain c%0d: got po16=%b r16=%0d po0=%b r0=%0d, want po=%b r16=%0d",
                         k, po16, r16, po0, r0, w_po[k], w_r16[k]);
            end
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 8; k++) begin
            int   wr;
            logic wp;
            wr = (k == 6) ? 32 : 0;
            wp = (k == 7);
            cycle(1'b1, k >= 6, k == 0, 16'h8000);
            total++;
            if ({po16, r16, po0, r0} !== {wp, 10'(wr), wp, 10'(wr == 0 ? 0 : wr - 16)}) begin
                bad++;
                $display("FAIL stall c%0d: got po16=%b r16=%0d po0=%b r0=%0d, want po=%b r16=%0d",
                         k, po16, r16, po0, r0, wp, wr);
            end
        end
    endtask

    task automatic test_recapture();
        int   w_r0[6] = '{0, 1, 2, 0, 2, 0};
        logic w_po[6] = '{0, 0, 0, 0, 0, 1};
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, 1'b1, (k == 0) || (k == 3), (k == 0) ? 16'hFFFF : 16'h0002);
            total++;
            if ({po0, r0, po16, r16} !== {w_po[k], 10'(w_r0[k]), w_po[k],
                                          10'(w_r0[k] == 0 ? 0 : w_r0[k] + 16)}) begin
                bad++;
                $display("FAIL recapture c%0d: got po0=%b r0=%0d po16=%b r16=%0d, want po=%b r0=%0d",
                         k, po0, r0, po16, r16, w_po[k], w_r0[k]);
            end
        end
    endtask

    task automatic test_empty_slice();
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b1, k == 0, 16'h0000);
            total++;
            if ({po0, r0, po16, r16} !== {k != 0, 10'd0, k != 0, 10'd0}) begin
                bad++;
                $display("FAIL empty_slice c%0d: got po0=%b r0=%0d po16=%b r16=%0d, want po=%b rule=0",
                         k, po0, r0, po16, r16, k != 0);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        int   w_r0[6] = '{0, 1, 2, 0, 0, 0};
        logic w_po[6] = '{0, 0, 0, 0, 1, 1};
        for (int k = 0; k < 6; k++) begin
            cycle(k != 3, 1'b1, k == 0, 16'h00FF);
            total++;
            if ({po0, r0, po16, r16} !== {w_po[k], 10'(w_r0[k]), w_po[k],
                                          10'(w_r0[k] == 0 ? 0 : w_r0[k] + 16)}) begin
                bad++;
                $display("FAIL reset_mid_scan c%0d: got po0=%b r0=%0d po16=%b r16=%0d, want po=%b r0=%0d",
                         k, po0, r0, po16, r16, w_po[k], w_r0[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int   w_r0[5] = '{0, 0, 5, 0, 0};
        logic w_po[5] = '{0, 0, 0, 1, 1};
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 1'b1, k < 2, (k == 0) ? 16'h0003 : 16'h0010);
            total++;
            if ({po0, r0, po16, r16} !== {w_po[k], 10'(w_r0[k]), w_po[k],
                                          10'(w_r0[k] == 0 ? 0 : w_r0[k] + 16)}) begin
                bad++;
                $display("FAIL back_to_back c%0d: got po0=%b r0=%0d po16=%b r16=%0d, want po=%b r0=%0d",
                         k, po0, r0, po16, r16, w_po[k], w_r0[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            logic        r, pi, e;
            logic [15:0] v;
            r  = ($urandom_range(0, 79) != 0);
            pi = ($urandom_range(0, 3) != 0);
            e  = ($urandom_range(0, 11) == 0);
            v  = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom & $urandom & $urandom);
            cycle(r, pi, e, v);
            total++;
            if ({po0, r0, po16, r16} !== {exp_po, exp_rule(0), exp_po, exp_rule(16)}) begin
                bad++;
                $display("FAIL random c%0d: got po0=%b r0=%0d po16=%b r16=%0d, want po=%b r0=%0d r16=%0d",
                         k, po0, r0, po16, r16, exp_po, exp_rule(0), exp_rule(16));
            end
        end
    endtask

    initial begin
        rst = 1'b0; perm_in = 1'b0; eop = 1'b0; vector = '0;
        exp_idx = -1; exp_po = 1'b0;
        test_reset();
        test_basic_drain();
        test_stall();
        test_recapture();
        test_empty_slice();
        test_reset_mid_scan();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
